mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single SRAM-like memory port between the fetch stage and the mem stage of the pipeline datapath. Sequences one outstanding transaction at a time over a req/addr_ok/data_ok handshake and returns read data to the owning requester. Generates the fetch stall (`stall_by_iram`) and the mem-stage stall. Discards fetches killed by a pipeline flush or exception redirect.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- inst_req  in  1  fetch request, level; held until inst_valid
- inst_addr  in  ADDR_W  fetch address (pcF)
- inst_cancel  in  1  flush; in-flight fetch result must be dropped
- inst_rdata  out  DATA_W  fetched word
- inst_valid  out  1  fetch completion, one-cycle pulse
- stall_inst  out  1  inst_req & ~inst_valid
- data_req  in  1  load/store request, level; held until data_valid
- data_wr  in  1  1 = store
- data_sel  in  4  byte enables (selM)
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data
- data_valid  out  1  load/store completion, one-cycle pulse
- stall_data  out  1  data_req & ~data_valid
- mem_req  out  1  bus request
- mem_wr  out  1  bus write
- mem_size  out  2  0 = byte, 1 = half, 2 = word
- mem_wstrb  out  4  byte strobes; 0 for reads
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_addr_ok  in  1  address phase accepted
- mem_data_ok  in  1  data phase complete
- mem_rdata  in  DATA_W  bus read data

## Operation
- States: IDLE, ADDR, DATA. Registered owner (INST/DATA), cancel flag, and latched request fields (wr, size, wstrb, addr, wdata).
- IDLE: if data_req, grant DATA; else if inst_req, grant INST. Latch the winner's fields. Go to ADDR. Data always has priority.
- ADDR: mem_req=1 with latched fields. On mem_addr_ok, go to DATA. A request is never withdrawn before addr_ok.
- DATA: mem_req=0. On mem_data_ok, go to IDLE.
  - For owner INST, assert inst_valid unless cancel is set.
  - For owner DATA, assert data_valid for both reads and writes.
- Completion outputs are combinational:
  - inst_valid = (state==DATA) & mem_data_ok & owner==INST & ~cancel
  - data_valid likewise for owner DATA
  - inst_rdata = data_rdata = mem_rdata
- Size encoding from data_sel:
  - one-hot → 0
  - 0011/1100 → 1
  - 1111 → 2
  - any other value → 2 with wstrb = data_sel passed through
- INST transactions use size 2 and wstrb 0. Addresses pass unmodified.
- inst_cancel while owner INST is in ADDR or DATA: set cancel. The transaction still completes on the bus, but its data is dropped. Cancel clears on leaving DATA.
- inst_cancel in IDLE, or while owner is DATA: no effect.
- A new inst_req arriving during a cancelled fetch waits. stall_inst stays high.
- data_req must already be gated by mem-stage exceptions (adelM/adesM) upstream. Data transactions are never cancelled.

## Timing
- Reset values: state IDLE, owner INST, cancel 0. All outputs 0: mem_req, valids, stalls, mem_size, mem_wstrb, mem_addr, mem_wdata, rdata.
- Minimum latency: req seen cycle 0 → mem_req cycle 1 (addr_ok same cycle) → data_ok and valid cycle 2. The requester drops req in cycle 3.
- Each extra cycle without mem_addr_ok or mem_data_ok adds one cycle of latency.
- Simultaneous inst_req and data_req in IDLE: DATA wins. INST is served next.
- rst mid-transaction: return to IDLE immediately. The outstanding bus transaction is abandoned; the slave shares the same rst.

## Configuration
- MEM_PORT_ARBITER_B2B_EN defined: in DATA with mem_data_ok, the arbiter grants a pending request from the non-owner directly and goes to ADDR. This removes the IDLE bubble. The completing owner's still-high req is excluded from this grant.
- Undefined: always pass through IDLE, so back-to-back transactions cost one extra cycle.

## Structure
- Package mem_port_arbiter_pkg: state encoding, OWNER_INST/OWNER_DATA, SIZE_BYTE/HALF/WORD constants.
- One sub-module: mem_size_enc (data_sel → mem_size, mem_wstrb). It is combinational.

## Test plan
- Fetch at 0xBFC00000, slave gives addr_ok and data_ok immediately, rdata 0x24010001 → inst_valid in cycle 2 with inst_rdata 0x24010001, stall_inst=0 in cycle 2.
- inst_req and data_req (load, sel 1111, addr 0x80000010) raised in the same cycle → bus address 0x80000010 first with data_valid; the fetch follows.
- Store with sel 0011 to 0x80000002, data 0x0000BEEF → mem_wr=1, mem_size=1, mem_wstrb=0011; data_valid pulses on data_ok.
- Fetch with data_ok delayed 3 cycles and inst_cancel pulsed in DATA → no inst_valid. A new fetch to 0xBFC00380 is issued only after data_ok.
- rst asserted while in DATA → next cycle state IDLE, mem_req=0, no valid pulses; a subsequent fetch completes normally.
- With MEM_PORT_ARBITER_B2B_EN: fetch completing while data_req is pending → mem_req for data asserted the cycle after data_ok (without the macro, two cycles after).

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the fetch/mem-stage memory port arbiter:
//   state_t      - arbiter FSM state encoding (IDLE, ADDR, DATA)
//   OWNER_*      - which requester owns the outstanding bus transaction
//   SIZE_*       - mem_size encodings driven on the bus
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_size_enc.sv
// mem_size_enc
// Combinational translation of the mem-stage byte-enable pattern into a bus
// transfer size and write strobes.
// Ports:
//   sel   in  4  byte enables from the mem stage
//   wr    in  1  1 = store (strobes are only driven for stores)
//   size  out 2  SIZE_BYTE for one-hot sel, SIZE_HALF for 0011/1100, else SIZE_WORD
//   wstrb out 4  sel passed through for stores, 0 for loads
module mem_size_enc
  import mem_port_arbiter_pkg::*;
(
  input  logic [3:0] sel,
  input  logic       wr,
  output logic [1:0] size,
  output logic [3:0] wstrb
);

  always_comb begin
    size = SIZE_WORD;
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      // Irregular patterns go out as a word access; the strobes carry the
      // actual byte lanes.
      default:                            size = SIZE_WORD;
    endcase
    wstrb = wr ? sel : 4'b0000;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one SRAM-like req/addr_ok/data_ok memory port between the fetch
// stage (inst_*) and the mem stage (data_*). One transaction is outstanding at
// a time; the data side always wins arbitration. Fetches hit by inst_cancel
// still complete on the bus but their data is dropped.
// Optional feature macro: MEM_PORT_ARBITER_B2B_EN - when defined, a pending
// request from the non-owner is granted directly on data_ok, skipping IDLE.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   inst_req/addr/cancel     fetch request, address, flush of in-flight fetch
//   inst_rdata/valid         fetched word and one-cycle completion pulse
//   stall_inst               inst_req & ~inst_valid
//   data_req/wr/sel/addr/wdata  mem-stage load/store request
//   data_rdata/valid         load data and one-cycle completion pulse
//   stall_data               data_req & ~data_valid
//   mem_req/wr/size/wstrb/addr/wdata  bus request side
//   mem_addr_ok/data_ok/rdata         bus responses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_valid,
  output logic              stall_inst,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              stall_data,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              cancel_reg, cancel_next;
  logic              wr_reg, wr_next;
  logic [1:0]        size_reg, size_next;
  logic [3:0]        wstrb_reg, wstrb_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;

  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic              grant_data, grant_inst;
  logic              done;

  mem_size_enc u_size_enc (
    .sel   (data_sel),
    .wr    (data_wr),
    .size  (data_size),
    .wstrb (data_wstrb)
  );

  assign done       = (state_reg == ST_DATA) && mem_data_ok;
  assign inst_valid = done && (owner_reg == OWNER_INST) && !cancel_reg;
  assign data_valid = done && (owner_reg == OWNER_DATA);
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign stall_inst = inst_req && !inst_valid;
  assign stall_data = data_req && !data_valid;

  assign mem_req   = (state_reg == ST_ADDR);
  assign mem_wr    = wr_reg;
  assign mem_size  = size_reg;
  assign mem_wstrb = wstrb_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    cancel_next = cancel_reg;
    wr_next     = wr_reg;
    size_next   = size_reg;
    wstrb_next  = wstrb_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    grant_data  = 1'b0;
    grant_inst  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (data_req)      grant_data = 1'b1;
        else if (inst_req) grant_inst = 1'b1;
      end
      ST_ADDR: begin
        if (mem_addr_ok) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (mem_data_ok) begin
          state_next  = ST_IDLE;
          cancel_next = 1'b0;
`ifdef MEM_PORT_ARBITER_B2B_EN
          // Only the other requester may be granted here: the completing
          // owner's req is still high this cycle but is already satisfied.
          if ((owner_reg == OWNER_INST) && data_req)      grant_data = 1'b1;
          else if ((owner_reg == OWNER_DATA) && inst_req) grant_inst = 1'b1;
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A flush only marks an in-flight fetch; the bus transaction runs to
    // completion and its data is dropped. Leaving DATA wins over a late flush.
    if (inst_cancel && (owner_reg == OWNER_INST) &&
        ((state_reg == ST_ADDR) || ((state_reg == ST_DATA) && !mem_data_ok)))
      cancel_next = 1'b1;

    if (grant_data) begin
      state_next  = ST_ADDR;
      owner_next  = OWNER_DATA;
      cancel_next = 1'b0;
      wr_next     = data_wr;
      size_next   = data_size;
      wstrb_next  = data_wstrb;
      addr_next   = data_addr;
      wdata_next  = data_wdata;
    end else if (grant_inst) begin
      state_next  = ST_ADDR;
      owner_next  = OWNER_INST;
      cancel_next = 1'b0;
      wr_next     = 1'b0;
      size_next   = SIZE_WORD;
      wstrb_next  = 4'b0000;
      addr_next   = inst_addr;
      wdata_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= OWNER_INST;
      cancel_reg <= 1'b0;
      wr_reg     <= 1'b0;
      size_reg   <= 2'd0;
      wstrb_reg  <= 4'b0000;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      cancel_reg <= cancel_next;
      wr_reg     <= wr_next;
      size_reg   <= size_next;
      wstrb_reg  <= wstrb_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: the bench plays both pipeline stages
// and the memory slave cycle by cycle and checks outputs on the falling edge.
// Honours MEM_PORT_ARBITER_B2B_EN for the back-to-back grant latency.
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARBITER_B2B_EN
  localparam int B2B_LAT = 0;
`else
  localparam int B2B_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr, inst_rdata;
  logic        inst_valid, stall_inst;
  logic        data_req, data_wr;
  logic [3:0]  data_sel;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_valid, stall_data;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_cancel (inst_cancel),
    .inst_rdata  (inst_rdata),
    .inst_valid  (inst_valid),
    .stall_inst  (stall_inst),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_sel    (data_sel),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_valid  (data_valid),
    .stall_data  (stall_data),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Serves one transaction whose request is already driven in the current
  // cycle: accepts the address as soon as mem_req appears, returns data the
  // next cycle, then drops the requester's req.
  task automatic serve(input string tag, input bit is_inst, input int exp_lat,
                       input logic [31:0] exp_addr, input logic exp_wr,
                       input logic [1:0] exp_size, input logic [3:0] exp_wstrb,
                       input logic [31:0] exp_wdata, input logic [31:0] rdata);
    int n;
    n = 0;
    mem_addr_ok = 1'b1;
    @(negedge clk);
    while (!mem_req && n < 8) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    check({tag, " lat"},   n, exp_lat);
    check({tag, " req"},   mem_req, 1'b1);
    check({tag, " addr"},  mem_addr, exp_addr);
    check({tag, " wr"},    mem_wr, exp_wr);
    check({tag, " size"},  mem_size, exp_size);
    check({tag, " wstrb"}, mem_wstrb, exp_wstrb);
    check({tag, " wdata"}, mem_wdata, exp_wdata);
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    @(negedge clk);
    if (is_inst) begin
      check({tag, " ivalid"}, inst_valid, 1'b1);
      check({tag, " dvalid"}, data_valid, 1'b0);
      check({tag, " rdata"},  inst_rdata, rdata);
      check({tag, " stall"},  stall_inst, 1'b0);
    end else begin
      check({tag, " dvalid"}, data_valid, 1'b1);
      check({tag, " ivalid"}, inst_valid, 1'b0);
      check({tag, " rdata"},  data_rdata, rdata);
      check({tag, " stall"},  stall_data, 1'b0);
    end
    $display("txn %s: addr=0x%08h wr=%0d size=%0d wstrb=%b lat=%0d", tag, mem_addr, mem_wr,
             mem_size, mem_wstrb, n);
    next_cycle();
    mem_data_ok = 1'b0;
    if (is_inst) inst_req = 1'b0;
    else         data_req = 1'b0;
  endtask

  // Store/load encoding vectors: wr, sel, addr, wdata, expected size, strobes.
  logic        v_wr    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0]  v_sel   [6] = '{4'b0011, 4'b0100, 4'b1100, 4'b0110, 4'b0001, 4'b1111};
  logic [31:0] v_addr  [6] = '{32'h8000_0002, 32'h8000_0106, 32'h8000_010A,
                               32'h8000_010C, 32'h8000_0110, 32'h8000_0114};
  logic [31:0] v_wdata [6] = '{32'h0000_BEEF, 32'h0055_0000, 32'hABCD_0000,
                               32'h0012_3400, 32'h0000_0000, 32'hCAFE_F00D};
  logic [1:0]  v_size  [6] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
  logic [3:0]  v_wstrb [6] = '{4'b0011, 4'b0100, 4'b1100, 4'b0110, 4'b0000, 4'b1111};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0; inst_cancel = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_sel = 4'b0000; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst mem_req",    mem_req, 1'b0);
    check("rst mem_wr",     mem_wr, 1'b0);
    check("rst mem_size",   mem_size, 2'd0);
    check("rst mem_wstrb",  mem_wstrb, 4'b0000);
    check("rst mem_addr",   mem_addr, 32'h0);
    check("rst mem_wdata",  mem_wdata, 32'h0);
    check("rst inst_valid", inst_valid, 1'b0);
    check("rst data_valid", data_valid, 1'b0);
    check("rst stall_inst", stall_inst, 1'b0);
    check("rst stall_data", stall_data, 1'b0);
    check("rst rdata",      inst_rdata, 32'h0);

    // Minimum-latency fetch, cycle by cycle.
    next_cycle();
    rst = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    @(negedge clk);
    check("f0 c0 mem_req", mem_req, 1'b0);
    check("f0 c0 stall",   stall_inst, 1'b1);
    next_cycle();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    check("f0 c1 mem_req", mem_req, 1'b1);
    check("f0 c1 addr",    mem_addr, 32'hBFC0_0000);
    check("f0 c1 size",    mem_size, 2'd2);
    check("f0 c1 wstrb",   mem_wstrb, 4'b0000);
    check("f0 c1 wr",      mem_wr, 1'b0);
    next_cycle();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h2401_0001;
    @(negedge clk);
    check("f0 c2 ivalid",  inst_valid, 1'b1);
    check("f0 c2 rdata",   inst_rdata, 32'h2401_0001);
    check("f0 c2 stall",   stall_inst, 1'b0);
    check("f0 c2 mem_req", mem_req, 1'b0);
    check("f0 c2 dvalid",  data_valid, 1'b0);
    $display("txn f0: fetch 0xbfc00000 rdata=0x%08h", inst_rdata);
    next_cycle();
    mem_data_ok = 1'b0; inst_req = 1'b0;
    @(negedge clk);
    check("f0 c3 ivalid",  inst_valid, 1'b0);
    check("f0 c3 mem_req", mem_req, 1'b0);

    // Simultaneous fetch and load: load first, fetch follows.
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b0; data_sel = 4'b1111;
    data_addr = 32'h8000_0010; data_wdata = 32'h0;
    serve("both load",  1'b0, 1, 32'h8000_0010, 1'b0, 2'd2, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    serve("both fetch", 1'b1, B2B_LAT, 32'hBFC0_0004, 1'b0, 2'd2, 4'b0000, 32'h0, 32'h3C1D_0000);

    // Size/strobe encoding through the data path.
    for (int i = 0; i < 6; i++) begin
      data_req = 1'b1; data_wr = v_wr[i]; data_sel = v_sel[i];
      data_addr = v_addr[i]; data_wdata = v_wdata[i];
      serve($sformatf("enc%0d", i), 1'b0, 1, v_addr[i], v_wr[i], v_size[i], v_wstrb[i],
            v_wdata[i], 32'h0000_1000 + i);
    end

    // Cancelled fetch with a 2-cycle address wait and a delayed data_ok.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("cx c1 mem_req", mem_req, 1'b1);
    next_cycle();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    check("cx c2 mem_req", mem_req, 1'b1);
    check("cx c2 addr",    mem_addr, 32'hBFC0_0100);
    next_cycle();
    mem_addr_ok = 1'b0; inst_cancel = 1'b1; inst_addr = 32'hBFC0_0380;
    @(negedge clk);
    check("cx c3 mem_req", mem_req, 1'b0);
    check("cx c3 ivalid",  inst_valid, 1'b0);
    next_cycle();
    inst_cancel = 1'b0;
    @(negedge clk);
    check("cx c4 ivalid",  inst_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("cx c5 mem_req", mem_req, 1'b0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("cx c6 ivalid",  inst_valid, 1'b0);
    check("cx c6 stall",   stall_inst, 1'b1);
    check("cx c6 mem_req", mem_req, 1'b0);
    $display("txn cx: fetch 0xbfc00100 cancelled, data dropped");
    next_cycle();
    mem_data_ok = 1'b0;
    serve("refetch", 1'b1, 1, 32'hBFC0_0380, 1'b0, 2'd2, 4'b0000, 32'h0, 32'h0800_00E0);

    // Reset while the fetch is in its data phase.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    @(negedge clk);
    next_cycle();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    check("rx c1 mem_req", mem_req, 1'b1);
    next_cycle();
    mem_addr_ok = 1'b0; rst = 1'b1; inst_req = 1'b0;
    @(negedge clk);
    next_cycle();
    rst = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("rx ivalid",  inst_valid, 1'b0);
    check("rx dvalid",  data_valid, 1'b0);
    check("rx mem_req", mem_req, 1'b0);
    check("rx addr",    mem_addr, 32'h0);
    $display("txn rx: fetch 0xbfc00200 abandoned by reset");
    next_cycle();
    mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
    serve("post rst", 1'b1, 1, 32'hBFC0_0300, 1'b0, 2'd2, 4'b0000, 32'h0, 32'h2402_0002);

    // Load raised while a fetch is in flight: back-to-back grant latency.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0400;
    mem_addr_ok = 1'b1;
    @(negedge clk);
    next_cycle();
    data_req = 1'b1; data_wr = 1'b0; data_sel = 4'b1111;
    data_addr = 32'h8000_0020; data_wdata = 32'h0;
    @(negedge clk);
    check("bb c1 addr", mem_addr, 32'hBFC0_0400);
    next_cycle();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("bb c2 ivalid", inst_valid, 1'b1);
    check("bb c2 dvalid", data_valid, 1'b0);
    check("bb c2 dstall", stall_data, 1'b1);
    $display("txn bb: fetch 0xbfc00400 rdata=0x%08h", inst_rdata);
    next_cycle();
    mem_data_ok = 1'b0; inst_req = 1'b0;
    serve("bb load", 1'b0, B2B_LAT, 32'h8000_0020, 1'b0, 2'd2, 4'b0000, 32'h0, 32'h3333_4444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
